// File: rtl/sr_latch_pulse_sequencer_pkg.sv
// Shared types for the SR latch pulse sequencer: FSM state encoding and latch op codes.
package cello_seq_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    PULSE,
    GUARD
  } seq_state_e;

  localparam logic OP_CLR = 1'b0;
  localparam logic OP_SET = 1'b1;

endpackage

// File: rtl/sr_latch_pulse_sequencer_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer; the pointer
// moves past the winner when the grant is consumed (adv).
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] grant_idx
);

  logic [W-1:0] ptr;
  logic         found;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    found        = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found     = 1'b1;
        grant_idx = W'((int'(ptr) + k) % N);
      end
    end
    if (found) grant_onehot = N'(1) << grant_idx;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv && found) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sr_latch_pulse_sequencer.sv
// Serialises set/clear commands from several requesters into timed, mutually exclusive
// S/R pulses on a NOR SR latch bank, and tracks the expected latch contents.
module sr_latch_pulse_sequencer
  import cello_seq_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int N_LATCH      = 8,
  parameter int IDX_W        = 3,
  parameter int PULSE_CYCLES = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*IDX_W-1:0]   req_idx,
  input  logic [N_REQ-1:0]         req_set,
  output logic [N_LATCH-1:0]       latch_s,
  output logic [N_LATCH-1:0]       latch_r,
  output logic [N_LATCH-1:0]       q_shadow,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES - 1);
  localparam seq_state_e RST_STATE = (INIT_CLEAR != 0) ? INIT : IDLE;

  seq_state_e         state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]   cur_idx, cur_idx_d, init_idx, init_idx_d;
  logic               cur_op, cur_op_d, init_phase, init_phase_d;
  logic [N_LATCH-1:0] s_d, r_d, q_d;
  logic               err_d, adv;

  logic [N_REQ-1:0]   grant_onehot;
  logic [GW-1:0]      grant_idx;
  logic [IDX_W-1:0]   g_idx;
  logic               g_op, g_idx_ok;

  function automatic logic [N_LATCH-1:0] lat_bit(input logic [IDX_W-1:0] i);
    return N_LATCH'(1) << i;
  endfunction

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (req_valid),
    .adv          (adv),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  assign g_idx     = req_idx[int'(grant_idx)*IDX_W +: IDX_W];
  assign g_op      = req_set[grant_idx];
  assign g_idx_ok  = int'(g_idx) < N_LATCH;
  assign req_ready = (state == IDLE) ? grant_onehot : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == GUARD) && (cnt == '0) && !init_phase;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    cur_idx_d    = cur_idx;
    cur_op_d     = cur_op;
    init_idx_d   = init_idx;
    init_phase_d = init_phase;
    s_d          = '0;
    r_d          = '0;
    q_d          = q_shadow;
    err_d        = 1'b0;
    adv          = 1'b0;
    unique case (state)
      INIT: begin
        state_d   = PULSE;
        cnt_d     = PULSE_LD;
        cur_idx_d = init_idx;
        cur_op_d  = OP_CLR;
        r_d       = lat_bit(init_idx);
      end
      IDLE: begin
        if (|req_valid) begin
          adv = 1'b1;
          if (g_idx_ok) begin
            state_d   = PULSE;
            cnt_d     = PULSE_LD;
            cur_idx_d = g_idx;
            cur_op_d  = g_op;
            if (g_op == OP_SET) s_d = lat_bit(g_idx);
            else                r_d = lat_bit(g_idx);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_d = GUARD;
          cnt_d   = GUARD_LD;
          q_d     = (q_shadow & ~lat_bit(cur_idx)) | (cur_op ? lat_bit(cur_idx) : '0);
        end else begin
          cnt_d = cnt - 1'b1;
          s_d   = latch_s;
          r_d   = latch_r;
        end
      end
      GUARD: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else if (!init_phase) begin
          state_d = IDLE;
        end else if (int'(init_idx) == N_LATCH - 1) begin
          state_d      = IDLE;
          init_phase_d = 1'b0;
        end else begin
          // Chain straight into the next latch's R pulse so the clear sweep has no gaps
          // beyond the guard time.
          state_d    = PULSE;
          cnt_d      = PULSE_LD;
          init_idx_d = init_idx + 1'b1;
          cur_idx_d  = init_idx + 1'b1;
          cur_op_d   = OP_CLR;
          r_d        = lat_bit(init_idx + 1'b1);
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RST_STATE;
      cnt        <= '0;
      cur_idx    <= '0;
      cur_op     <= OP_CLR;
      init_idx   <= '0;
      init_phase <= (INIT_CLEAR != 0);
      latch_s    <= '0;
      latch_r    <= '0;
      q_shadow   <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cur_idx    <= cur_idx_d;
      cur_op     <= cur_op_d;
      init_idx   <= init_idx_d;
      init_phase <= init_phase_d;
      latch_s    <= s_d;
      latch_r    <= r_d;
      q_shadow   <= q_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_sr_latch_pulse_sequencer.sv
// Self-checking bench for sr_latch_pulse_sequencer: directed and random commands compared
// against a transaction-level model of grant order, pulse timing and expected latch state.
module tb_sr_latch_pulse_sequencer;

  localparam int NR = 4;
  localparam int NL = 8;
  localparam int IW = 4;
  localparam int PC = 4;
  localparam int GC = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*IW-1:0] req_idx;
  logic [NR-1:0]    req_set;
  logic [NL-1:0]    latch_s, latch_r, q_shadow;
  logic             busy, done, err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int           rr_m;
  logic [NL-1:0] q_m;
  logic [IW-1:0] drv_idx [NR];
  logic          drv_set [NR];
  int            order_q [$];

  always #5 clk = ~clk;

  sr_latch_pulse_sequencer #(
    .N_REQ(NR), .N_LATCH(NL), .IDX_W(IW),
    .PULSE_CYCLES(PC), .GUARD_CYCLES(GC), .INIT_CLEAR(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .req_set   (req_set),
    .latch_s   (latch_s),
    .latch_r   (latch_r),
    .q_shadow  (q_shadow),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // S and R never overlap and at most one latch is driven, on every cycle.
  always @(negedge clk) begin
    n_vec++;
    assert (((latch_s & latch_r) == '0) && ($countones(latch_s | latch_r) <= 1)) else begin
      n_err++;
      $error("FAIL sr_exclusive observed s=%0h r=%0h expected disjoint and at most one bit", latch_s, latch_r);
    end
  end

  function automatic int pick(input logic [NR-1:0] m);
    for (int k = 0; k < NR; k++)
      if (m[(rr_m + k) % NR]) return (rr_m + k) % NR;
    return -1;
  endfunction

  // Entered on the negedge of the first cycle after reset release; returns on an IDLE negedge.
  task automatic init_check();
    check("init_busy", busy, 1);
    check("init_ready", req_ready, 0);
    check("init_r0", latch_r, 0);
    req_valid = 4'($urandom_range(15, 1));
    for (int i = 0; i < NL; i++) begin
      for (int c = 0; c < PC + GC; c++) begin
        @(negedge clk);
        check("init_r", latch_r, (c < PC) ? (32'd1 << i) : 32'd0);
        check("init_s", latch_s, 0);
        check("init_ready_held", req_ready, 0);
        check("init_done", done, 0);
        check("init_busy_hi", busy, 1);
        req_valid = (i == NL - 1 && c == PC + GC - 1) ? '0 : 4'($urandom_range(15, 1));
      end
    end
    @(negedge clk);
    check("init_busy_lo", busy, 0);
    check("init_q", q_shadow, 0);
    rr_m = 0;
    q_m  = '0;
  endtask

  // Serve every requester in mask; optionally re-raise requester 0 once after its grant.
  task automatic serve(input logic [NR-1:0] mask, input bit reassert0);
    logic [NR-1:0] pend;
    logic [NL-1:0] bitv;
    bit reas;
    int w;
    pend = mask;
    reas = reassert0;
    while (pend != '0) begin
      req_valid = pend;
      for (int r = 0; r < NR; r++) begin
        req_idx[r*IW +: IW] = drv_idx[r];
        req_set[r]          = drv_set[r];
      end
      #1;
      w = pick(pend);
      check("grant_ready", req_ready, 32'd1 << w);
      check("idle_busy", busy, 0);
      @(posedge clk);
      order_q.push_back(w);
      rr_m    = (w + 1) % NR;
      pend[w] = 1'b0;
      if (reas && w == 0) begin
        pend[0] = 1'b1;
        reas    = 1'b0;
      end
      @(negedge clk);
      req_valid = pend;
      if (int'(drv_idx[w]) < NL) begin
        bitv = NL'(1) << drv_idx[w];
        for (int p = 0; p < PC; p++) begin
          if (p > 0) @(negedge clk);
          check("pulse_s", latch_s, drv_set[w] ? bitv : '0);
          check("pulse_r", latch_r, drv_set[w] ? '0 : bitv);
          check("pulse_ready", req_ready, 0);
          check("pulse_done", done, 0);
          check("pulse_q", q_shadow, q_m);
        end
        q_m[drv_idx[w]] = drv_set[w];
        for (int g = 0; g < GC; g++) begin
          @(negedge clk);
          check("guard_sr", latch_s | latch_r, 0);
          check("guard_done", done, (g == GC - 1) ? 1 : 0);
          check("guard_q", q_shadow, q_m);
        end
        @(negedge clk);
      end else begin
        check("bad_err", err, 1);
        check("bad_busy", busy, 0);
        check("bad_sr", latch_s | latch_r, 0);
        check("bad_done", done, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_idx = '0; req_set = '0;
    for (int r = 0; r < NR; r++) begin drv_idx[r] = '0; drv_set[r] = 1'b0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s", latch_s, 0);
    check("rst_r", latch_r, 0);
    check("rst_q", q_shadow, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    init_check();

    // Requester 1 sets latch 5.
    drv_idx[1] = 4'd5; drv_set[1] = 1'b1;
    serve(4'b0010, 1'b0);
    check("set5_q", q_shadow, 8'h20);

    // Requester 3 clears latch 5; pointer wraps back to 0.
    drv_idx[3] = 4'd5; drv_set[3] = 1'b0;
    serve(4'b1000, 1'b0);
    check("clr5_q", q_shadow, 8'h00);

    // All four at once, requester 0 re-raised after its first grant.
    for (int r = 0; r < NR; r++) begin drv_idx[r] = 4'(r); drv_set[r] = 1'b1; end
    order_q.delete();
    serve(4'b1111, 1'b1);
    check("order_len", order_q.size(), 5);
    check("order0", order_q[0], 0);
    check("order1", order_q[1], 1);
    check("order2", order_q[2], 2);
    check("order3", order_q[3], 3);
    check("order4", order_q[4], 0);

    // Out-of-range index: error pulse only, no pulse, no done.
    drv_idx[2] = 4'd9; drv_set[2] = 1'b1;
    serve(4'b0100, 1'b0);
    check("bad_rr", pick(4'b1111), 3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bad_after_err", err, 0);
      check("bad_after_done", done, 0);
      check("bad_after_sr", latch_s | latch_r, 0);
      check("bad_after_busy", busy, 0);
    end

    // Redundant set on latch 7.
    drv_idx[0] = 4'd7; drv_set[0] = 1'b1;
    serve(4'b0001, 1'b0);
    serve(4'b0001, 1'b0);

    // Random traffic.
    for (int n = 0; n < 25; n++) begin
      for (int r = 0; r < NR; r++) begin
        drv_idx[r] = 4'($urandom_range(9, 0));
        drv_set[r] = 1'($urandom_range(1, 0));
      end
      serve(4'($urandom_range(15, 1)), 1'b0);
    end
    check("rand_q", q_shadow, q_m);

    // Reset during the second pulse cycle.
    req_valid = 4'b0001;
    req_idx[0 +: IW] = 4'd3;
    req_set[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    check("mid_p1", latch_s, 8'h08);
    @(negedge clk);
    check("mid_p2", latch_s, 8'h08);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_s", latch_s, 0);
    check("mid_rst_r", latch_r, 0);
    check("mid_rst_q", q_shadow, 0);
    check("mid_rst_busy", busy, 1);
    rst = 1'b0;
    init_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
